axi_subordinate_mem: RTL and testbench

- AXI4-Lite-style subordinate endpoint that answers the manager's AW/W/B/AR/R channels.
- Backed by a word-addressed internal memory; one entry per DATA_W-bit line, no byte strobes.
- Write path and read path are independent FSMs, each with one outstanding transaction.
- Sits on the subordinate side of axi4_if and serves as the bench target and the simple on-chip memory model.

---
 rtl/axi_subordinate_mem.sv | 207 ++++++++++++++++++++
 tb/tb_axi_subordinate_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_subordinate_mem.sv
// axi_subordinate_mem
//   AXI4-Lite-style subordinate backed by a word-addressed memory (one
//   DATA_W-bit line per index, no byte strobes). Write and read paths are
//   independent FSMs, each allowing one outstanding transaction.
//
// Ports
//   ACLK, ARESET            clock (rising edge), async active-high reset
//   AWADDR/AWVALID/AWREADY  write address channel (address = line index)
//   WDATA/WVALID/WREADY     write data channel
//   BRESP/BVALID/BREADY     write response (00 OKAY, 11 DECERR)
//   ARADDR/ARVALID/ARREADY  read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//   wr_done, rd_done        one-cycle pulses on B / R handshake completion
module axi_subordinate_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              wr_done,
    output logic              rd_done
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Any address bit above the index field makes the access out of range.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) == '0;
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t          w_state, w_state_n;
    logic              aw_cap, aw_cap_n, w_cap, w_cap_n;
    logic [ADDR_W-1:0] aw_addr, aw_addr_n;
    logic [DATA_W-1:0] w_data, w_data_n;
    logic              awready_n, wready_n, bvalid_n, wr_done_n;
    logic [1:0]        bresp_n;
    logic              mem_we;

    always_comb begin
        w_state_n = w_state;
        aw_cap_n  = aw_cap;
        w_cap_n   = w_cap;
        aw_addr_n = aw_addr;
        w_data_n  = w_data;
        awready_n = AWREADY;
        wready_n  = WREADY;
        bvalid_n  = BVALID;
        bresp_n   = BRESP;
        wr_done_n = 1'b0;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    aw_cap_n  = 1'b1;
                    aw_addr_n = AWADDR;
                end
                if (WVALID && WREADY) begin
                    w_cap_n  = 1'b1;
                    w_data_n = WDATA;
                end
                // Both halves in hand (possibly on this very edge): commit the
                // write now so BVALID shows up in the following cycle.
                if (aw_cap_n && w_cap_n) begin
                    mem_we    = in_range(aw_addr_n);
                    bresp_n   = in_range(aw_addr_n) ? RESP_OKAY : RESP_DECERR;
                    bvalid_n  = 1'b1;
                    aw_cap_n  = 1'b0;
                    w_cap_n   = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    w_state_n = W_RESP;
                end else begin
                    // Also raises READY on the first edge after reset.
                    awready_n = !aw_cap_n;
                    wready_n  = !w_cap_n;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_n  = 1'b0;
                    wr_done_n = 1'b1;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            wr_done <= 1'b0;
        end else begin
            w_state <= w_state_n;
            aw_cap  <= aw_cap_n;
            w_cap   <= w_cap_n;
            aw_addr <= aw_addr_n;
            w_data  <= w_data_n;
            AWREADY <= awready_n;
            WREADY  <= wready_n;
            BVALID  <= bvalid_n;
            BRESP   <= bresp_n;
            wr_done <= wr_done_n;
        end
    end

    // Memory contents survive reset; a read on the same edge sees old data.
    always_ff @(posedge ACLK) begin
        if (mem_we)
            mem[aw_addr_n[IDX_W-1:0]] <= w_data_n;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t          r_state, r_state_n;
    logic              arready_n, rvalid_n, rd_done_n;
    logic [DATA_W-1:0] rdata_n;
    logic [1:0]        rresp_n;

    always_comb begin
        r_state_n = r_state;
        arready_n = ARREADY;
        rvalid_n  = RVALID;
        rdata_n   = RDATA;
        rresp_n   = RRESP;
        rd_done_n = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = in_range(ARADDR) ? mem[ARADDR[IDX_W-1:0]] : '0;
                    rresp_n   = in_range(ARADDR) ? RESP_OKAY : RESP_DECERR;
                    r_state_n = R_DATA;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_n  = 1'b0;
                    rd_done_n = 1'b1;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            rd_done <= 1'b0;
        end else begin
            r_state <= r_state_n;
            ARREADY <= arready_n;
            RVALID  <= rvalid_n;
            RDATA   <= rdata_n;
            RRESP   <= rresp_n;
            rd_done <= rd_done_n;
        end
    end

endmodule

// File: tb/tb_axi_subordinate_mem.sv
module tb_axi_subordinate_mem;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int BUDGET    = 20;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              wr_done, rd_done;

    axi_subordinate_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .wr_done(wr_done), .rd_done(rd_done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } r_exp_t;

    logic [1:0]        exp_b[$];
    r_exp_t            exp_r[$];
    logic [DATA_W-1:0] model [MEM_DEPTH];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < MEM_DEPTH;
    endfunction

    function automatic r_exp_t read_exp(input logic [ADDR_W-1:0] a);
        r_exp_t e;
        e.data = in_range(a) ? model[a[9:0]] : '0;
        e.resp = in_range(a) ? 2'b00 : 2'b11;
        return e;
    endfunction

    // Bounded wait at negedges for a READY output to be high.
    task automatic wait_ready(input string tag, input int which);
        int n = 0;
        logic s;
        s = (which == 0) ? AWREADY : (which == 1) ? WREADY : ARREADY;
        while (!s && n < BUDGET) begin
            @(negedge ACLK);
            n++;
            s = (which == 0) ? AWREADY : (which == 1) ? WREADY : ARREADY;
        end
        check(tag, s, 1'b1);
    endtask

    // Write with BREADY held high. w_lead=0: AW and W together; otherwise W
    // goes first and AW follows w_lead cycles later.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int w_lead);
        logic [1:0] eb;
        exp_b.push_back(in_range(a) ? 2'b00 : 2'b11);
        if (in_range(a)) model[a[9:0]] = d;
        BREADY = 1'b1;
        if (w_lead > 0) begin
            WVALID = 1'b1; WDATA = d;
            wait_ready("wready_wait", 1);
            @(posedge ACLK); @(negedge ACLK);
            WVALID = 1'b0;
            check("wready_drop", WREADY, 1'b0);
            check("bvalid_early", BVALID, 1'b0);
            repeat (w_lead - 1) @(negedge ACLK);
            AWVALID = 1'b1; AWADDR = a;
            wait_ready("awready_wait", 0);
            @(posedge ACLK); @(negedge ACLK);
            AWVALID = 1'b0;
        end else begin
            AWVALID = 1'b1; AWADDR = a;
            WVALID = 1'b1; WDATA = d;
            wait_ready("awready_wait", 0);
            wait_ready("wready_wait", 1);
            @(posedge ACLK); @(negedge ACLK);
            AWVALID = 1'b0; WVALID = 1'b0;
        end
        check("bvalid_lat", BVALID, 1'b1);
        check("awready_busy", AWREADY, 1'b0);
        eb = exp_b.pop_front();
        check("bresp", BRESP, eb);
        @(posedge ACLK); @(negedge ACLK);
        check("wr_done", wr_done, 1'b1);
        check("bvalid_clr", BVALID, 1'b0);
        check("awready_back", AWREADY, 1'b1);
        check("wready_back", WREADY, 1'b1);
        @(negedge ACLK);
        check("wr_done_pulse", wr_done, 1'b0);
    endtask

    // Read with RREADY held low for rdelay cycles of valid data.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int rdelay);
        r_exp_t e;
        exp_r.push_back(read_exp(a));
        ARVALID = 1'b1; ARADDR = a;
        RREADY = (rdelay == 0);
        wait_ready("arready_wait", 2);
        @(posedge ACLK); @(negedge ACLK);
        ARVALID = 1'b0;
        check("rvalid_lat", RVALID, 1'b1);
        e = exp_r.pop_front();
        check("rdata", RDATA, e.data);
        check("rresp", RRESP, e.resp);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge ACLK);
            check("rvalid_hold", RVALID, 1'b1);
            check("rdata_hold", RDATA, e.data);
            check("arready_busy", ARREADY, 1'b0);
            check("rd_done_early", rd_done, 1'b0);
        end
        RREADY = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        check("rd_done", rd_done, 1'b1);
        check("rvalid_clr", RVALID, 1'b0);
        check("arready_back", ARREADY, 1'b1);
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        r_exp_t er;
        logic [1:0] eb;

        // Reset state
        @(negedge ACLK); @(negedge ACLK);
        check("rst_awready", AWREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_done", {wr_done, rd_done}, 2'b00);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rel_awready", AWREADY, 1'b1);
        check("rel_wready", WREADY, 1'b1);
        check("rel_arready", ARREADY, 1'b1);

        // Same-cycle AW/W
        do_write(32'h5, 32'hDEADBEEF, 0);
        // W three cycles ahead of AW, then read back
        do_write(32'h7, 32'h1234, 3);
        do_read(32'h7, 0);
        // Held read with RREADY low for 4 cycles
        do_read(32'h5, 4);

        // Out of range write must not touch line 0 (aliased index)
        do_write(32'h0, 32'h0BAD, 0);
        do_write(32'h400, 32'hFFFF, 0);
        do_read(32'h0, 0);
        do_read(32'h400, 0);

        // Write and AR to the same index on the same edge: old data returned
        do_write(32'h9, 32'h5555, 0);
        exp_b.push_back(2'b00);
        exp_r.push_back(read_exp(32'h9));
        model[9] = 32'hAAAA;
        BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = 32'h9; WVALID = 1'b1; WDATA = 32'hAAAA;
        ARVALID = 1'b1; ARADDR = 32'h9;
        @(posedge ACLK); @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("coll_bvalid", BVALID, 1'b1);
        eb = exp_b.pop_front();
        check("coll_bresp", BRESP, eb);
        check("coll_rvalid", RVALID, 1'b1);
        er = exp_r.pop_front();
        check("coll_rdata", RDATA, er.data);
        @(posedge ACLK); @(negedge ACLK);
        check("coll_done", {wr_done, rd_done}, 2'b11);
        RREADY = 1'b0;
        do_read(32'h9, 0);

        // Reset while BVALID is high
        BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h3; WVALID = 1'b1; WDATA = 32'hC0FFEE;
        @(posedge ACLK); @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        model[3] = 32'hC0FFEE;
        check("pre_rst_bvalid", BVALID, 1'b1);
        #2 ARESET = 1'b1;
        #1;
        check("mid_rst_bvalid", BVALID, 1'b0);
        check("mid_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        BREADY = 1'b1;
        @(negedge ACLK);
        check("mid_rst_hold", {AWREADY, WREADY, ARREADY, wr_done}, 4'b0000);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        check("post_rst_bvalid", BVALID, 1'b0);
        check("post_rst_wr_done", wr_done, 1'b0);
        BREADY = 1'b0;
        // Write committed before reset persists
        do_read(32'h3, 0);

        check("sb_empty", exp_b.size() + exp_r.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
